// File: rtl/gerenciador_ativos.sv
// gerenciador_ativos
// Frontier table for the parallel Dijkstra expansion. Absorbs update and
// deactivate pulses from the neighbour locator, keeps the best distance per
// node and, when asked to evaluate, approves up to NUM_NA nodes whose
// distance does not exceed the smallest (distancia + menor_vizinho) bound in
// the table.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   lvv_atualizar_in + fields  insert/update a node (accepted only when idle)
//   lvv_desativar_in + addr    invalidate a node (accepted in any state)
//   cme_avaliar_in             start an evaluation (queued if busy)
//   aa_ocupado_out             high in every state but idle
//   aa_aprovado_out            per-slot valid bits of the last evaluation
//   aa_endereco/distancia/anterior_out  packed slot data, slot k at k*W
//   aa_tem_ativo_out           at least one valid entry (registered)
//   aa_tem_aprovado_out        OR of the approved bits, set at completion
//   aa_erro_out                sticky: table overflow or update while busy
module gerenciador_ativos #(
  parameter int ADDR_WIDTH      = 8,
  parameter int NUM_NA          = 4,
  parameter int DISTANCIA_WIDTH = 5,
  parameter int CUSTO_WIDTH     = 4,
  parameter int NUM_ATIVOS      = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            lvv_atualizar_in,
  input  logic [ADDR_WIDTH-1:0]           lvv_endereco_in,
  input  logic [CUSTO_WIDTH-1:0]          lvv_menor_vizinho_in,
  input  logic [DISTANCIA_WIDTH-1:0]      lvv_distancia_in,
  input  logic [ADDR_WIDTH-1:0]           lvv_anterior_in,
  input  logic                            lvv_desativar_in,
  input  logic [ADDR_WIDTH-1:0]           lvv_desativar_addr_in,
  input  logic                            cme_avaliar_in,
  output logic                            aa_ocupado_out,
  output logic [NUM_NA-1:0]               aa_aprovado_out,
  output logic [ADDR_WIDTH*NUM_NA-1:0]    aa_endereco_out,
  output logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_out,
  output logic [ADDR_WIDTH*NUM_NA-1:0]    aa_anterior_out,
  output logic                            aa_tem_ativo_out,
  output logic                            aa_tem_aprovado_out,
  output logic                            aa_erro_out
);

  localparam int IW = $clog2(NUM_ATIVOS);
  localparam int KW = $clog2(NUM_NA) + 1;
  localparam int SW = DISTANCIA_WIDTH + 1;
  localparam logic [IW-1:0] ULTIMO = IW'(NUM_ATIVOS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATUALIZAR,
    ST_MINIMO,
    ST_APROVAR,
    ST_CONCLUIR
  } estado_t;

  // distancia + menor_vizinho widened by one bit so the sum never wraps
  function automatic logic [SW-1:0] soma_ext(input logic [DISTANCIA_WIDTH-1:0] d,
                                             input logic [CUSTO_WIDTH-1:0] c);
    return {1'b0, d} + SW'(c);
  endfunction

  estado_t                    estado;
  logic [NUM_ATIVOS-1:0]      valid;
  logic [ADDR_WIDTH-1:0]      ent_end  [NUM_ATIVOS];
  logic [DISTANCIA_WIDTH-1:0] ent_dist [NUM_ATIVOS];
  logic [CUSTO_WIDTH-1:0]     ent_mv   [NUM_ATIVOS];
  logic [ADDR_WIDTH-1:0]      ent_ant  [NUM_ATIVOS];

  logic [ADDR_WIDTH-1:0]      upd_end;
  logic [DISTANCIA_WIDTH-1:0] upd_dist;
  logic [CUSTO_WIDTH-1:0]     upd_mv;
  logic [ADDR_WIDTH-1:0]      upd_ant;

  logic                       pendente;
  logic [IW-1:0]              idx;
  logic [SW-1:0]              limite;
  logic [KW-1:0]              k;

  logic                       hit;
  logic [IW-1:0]              hit_idx;
  logic                       livre;
  logic [IW-1:0]              livre_idx;
  logic                       desat_upd;
  logic [SW-1:0]              cand_soma;
  logic                       cand_ok;
  logic [KW-1:0]              k_next;

  // Parallel address match and lowest free slot; the loop runs downward so
  // the last assignment is the lowest index.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    livre     = 1'b0;
    livre_idx = '0;
    for (int i = NUM_ATIVOS - 1; i >= 0; i--) begin
      if (valid[i] && (ent_end[i] == upd_end)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        livre     = 1'b1;
        livre_idx = IW'(i);
      end
    end
  end

  assign desat_upd = lvv_desativar_in && (lvv_desativar_addr_in == upd_end);
  assign cand_soma = soma_ext(ent_dist[idx], ent_mv[idx]);
  assign cand_ok   = valid[idx] && ({1'b0, ent_dist[idx]} <= limite);
  assign k_next    = k + KW'(cand_ok);

  // Entry payload and latched update fields; only the valid bits need reset.
  always_ff @(posedge clk) begin
    if ((estado == ST_IDLE) && lvv_atualizar_in) begin
      upd_end  <= lvv_endereco_in;
      upd_dist <= lvv_distancia_in;
      upd_mv   <= lvv_menor_vizinho_in;
      upd_ant  <= lvv_anterior_in;
    end
    if (estado == ST_ATUALIZAR) begin
      if (hit) begin
        if (upd_dist < ent_dist[hit_idx]) begin
          ent_dist[hit_idx] <= upd_dist;
          ent_mv[hit_idx]   <= upd_mv;
          ent_ant[hit_idx]  <= upd_ant;
        end
      end else if (livre) begin
        ent_end[livre_idx]  <= upd_end;
        ent_dist[livre_idx] <= upd_dist;
        ent_mv[livre_idx]   <= upd_mv;
        ent_ant[livre_idx]  <= upd_ant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado              <= ST_IDLE;
      valid               <= '0;
      pendente            <= 1'b0;
      idx                 <= '0;
      limite              <= '1;
      k                   <= '0;
      aa_ocupado_out      <= 1'b0;
      aa_aprovado_out     <= '0;
      aa_endereco_out     <= '0;
      aa_distancia_out    <= '0;
      aa_anterior_out     <= '0;
      aa_tem_ativo_out    <= 1'b0;
      aa_tem_aprovado_out <= 1'b0;
      aa_erro_out         <= 1'b0;
    end else begin
      aa_tem_ativo_out <= |valid;

      case (estado)
        ST_IDLE: begin
          if (lvv_atualizar_in) begin
            estado         <= ST_ATUALIZAR;
            aa_ocupado_out <= 1'b1;
            if (cme_avaliar_in) pendente <= 1'b1;
          end else if (cme_avaliar_in || pendente) begin
            aa_aprovado_out     <= '0;
            aa_endereco_out     <= '0;
            aa_distancia_out    <= '0;
            aa_anterior_out     <= '0;
            aa_tem_aprovado_out <= 1'b0;
            pendente            <= 1'b0;
            idx                 <= '0;
            limite              <= '1;
            k                   <= '0;
            estado              <= ST_MINIMO;
            aa_ocupado_out      <= 1'b1;
          end
        end

        // ---- update: existing entry handled in the payload block ----
        ST_ATUALIZAR: begin
          if (!hit) begin
            if (livre) valid[livre_idx] <= !desat_upd;
            else       aa_erro_out      <= 1'b1;
          end
          estado         <= ST_IDLE;
          aa_ocupado_out <= 1'b0;
        end

        // ---- minimum bound scan, one entry per cycle ----
        ST_MINIMO: begin
          if (valid[idx] && (cand_soma < limite)) limite <= cand_soma;
          if (idx == ULTIMO) begin
            idx    <= '0;
            estado <= ST_APROVAR;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        // ---- approval scan, fills slots lowest index first ----
        ST_APROVAR: begin
          if (cand_ok) begin
            for (int s = 0; s < NUM_NA; s++) begin
              if (k == KW'(s)) begin
                aa_aprovado_out[s]                                   <= 1'b1;
                aa_endereco_out[s*ADDR_WIDTH +: ADDR_WIDTH]          <= ent_end[idx];
                aa_distancia_out[s*DISTANCIA_WIDTH +: DISTANCIA_WIDTH] <= ent_dist[idx];
                aa_anterior_out[s*ADDR_WIDTH +: ADDR_WIDTH]          <= ent_ant[idx];
              end
            end
          end
          k <= k_next;
          if ((k_next == KW'(NUM_NA)) || (idx == ULTIMO)) estado <= ST_CONCLUIR;
          else                                            idx    <= idx + 1'b1;
        end

        ST_CONCLUIR: begin
          aa_tem_aprovado_out <= |aa_aprovado_out;
          estado              <= ST_IDLE;
          aa_ocupado_out      <= 1'b0;
        end

        default: begin
          estado         <= ST_IDLE;
          aa_ocupado_out <= 1'b0;
        end
      endcase

      if (estado != ST_IDLE) begin
        if (lvv_atualizar_in) aa_erro_out <= 1'b1;
        if (cme_avaliar_in)   pendente    <= 1'b1;
      end

      // Deactivation is applied last so it overrides a same-cycle write.
      if (lvv_desativar_in) begin
        for (int i = 0; i < NUM_ATIVOS; i++) begin
          if (valid[i] && (ent_end[i] == lvv_desativar_addr_in)) valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
